// File: rtl/mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_pkg                                                          |
// | Shared encodings for the MEM-stage data bridge.                  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDSK   = 2'd1,
    WAITLD = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  typedef struct packed {
    logic       wr;
    logic [1:0] off;
    logic [1:0] size;
    logic       sgn;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  // Returns {legal, size[1:0], off[1:0]} for a store byte-enable code.
  function automatic logic [4:0] decode_be(input logic [3:0] be);
    logic [4:0] r;
    case (be)
      BE_B0:   r = {1'b1, SZ_BYTE, 2'd0};
      BE_B1:   r = {1'b1, SZ_BYTE, 2'd1};
      BE_B2:   r = {1'b1, SZ_BYTE, 2'd2};
      BE_B3:   r = {1'b1, SZ_BYTE, 2'd3};
      BE_H0:   r = {1'b1, SZ_HALF, 2'd0};
      BE_H1:   r = {1'b1, SZ_HALF, 2'd2};
      BE_W:    r = {1'b1, SZ_WORD, 2'd0};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tag_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tag_fifo                                                         |
// | In-order tag queue for outstanding bus transactions.             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  // Push looks only at the current count, so a same-cycle pop never frees room.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (do_pop) rptr_q <= ptr_inc(rptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_sram_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_sram_bridge                                                 |
// | MEM-stage load/store bridge onto the SRAM-like data bus.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module data_sram_bridge
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 2,
  parameter int MASK_HI = 3
) (
  input  logic              clk,
  input  logic              rst,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic [31:0]       data_rdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic              MemRead,
  input  logic [3:0]        MemWrite,
  input  logic [1:0]        LoadSize,
  input  logic              LoadSigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              be_err,
  output logic              stall,
  output logic              CLR
);

  localparam logic [ADDR_W-1:0] ADDR_KEEP = {ADDR_W{1'b1}} >> MASK_HI;

  state_t             state_q, state_d;
  logic [ADDR_W-1:2]  cap_addr_q;
  logic [31:0]        cap_wdata_q;
  tag_t               cap_tag_q;

  logic [4:0]         be_dec;
  logic               ld_mis, op_ok, op_err;
  tag_t               live_tag, bus_tag, head_tag;
  logic [TAG_W-1:0]   fifo_head;
  logic               fifo_full, fifo_empty, pop_ok;
  logic               req, use_cap, push, capture, stall_c, err_c, lv_c;
  logic [ADDR_W-1:2]  bus_addr_hi;
  logic [31:0]        lane, ext;

  assign be_dec = decode_be(MemWrite);
  assign ld_mis = (LoadSize == SZ_HALF && addr[0]) ||
                  (LoadSize == SZ_WORD && addr[1:0] != 2'b00);
  assign op_ok  = MemRead ? !ld_mis : be_dec[4];
  assign op_err = MemRead ? ld_mis  : (MemWrite != 4'b0000 && !be_dec[4]);

  always_comb begin
    live_tag.wr   = !MemRead;
    live_tag.off  = MemRead ? addr[1:0] : be_dec[1:0];
    live_tag.size = MemRead ? LoadSize  : be_dec[3:2];
    live_tag.sgn  = MemRead && LoadSigned;
  end

  tag_fifo #(.DEPTH(MAX_OUT), .WIDTH(TAG_W)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (data_data_ok),
    .din   (use_cap ? cap_tag_q : live_tag),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign head_tag = tag_t'(fifo_head);
  assign pop_ok   = data_data_ok && !fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        cap_addr_q  <= addr[ADDR_W-1:2];
        cap_wdata_q <= wdata;
        cap_tag_q   <= live_tag;
      end
    end
  end

  // Outputs are qualified by rst so everything reads zero while reset is held.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    use_cap = 1'b0;
    push    = 1'b0;
    capture = 1'b0;
    stall_c = 1'b0;
    err_c   = 1'b0;
    lv_c    = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          err_c = op_err;
          if (op_ok) begin
            if (fifo_full) begin
              state_d = DRAIN;
              stall_c = 1'b1;
            end else begin
              req     = 1'b1;
              capture = 1'b1;
              if (data_addr_ok) begin
                push = 1'b1;
                if (!live_tag.wr) begin
                  state_d = WAITLD;
                  stall_c = 1'b1;
                end
              end else begin
                state_d = HDSK;
                stall_c = 1'b1;
              end
            end
          end
        end
        HDSK: begin
          req     = 1'b1;
          use_cap = 1'b1;
          stall_c = 1'b1;
          if (data_addr_ok) begin
            push    = 1'b1;
            state_d = cap_tag_q.wr ? IDLE : WAITLD;
            stall_c = !cap_tag_q.wr;
          end
        end
        DRAIN: begin
          stall_c = 1'b1;
          if (pop_ok) state_d = IDLE;
        end
        WAITLD: begin
          stall_c = 1'b1;
          // The pending load is always the youngest tag; older stores drain silently.
          if (pop_ok && !head_tag.wr) begin
            lv_c    = 1'b1;
            stall_c = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus_tag     = use_cap ? cap_tag_q : live_tag;
  assign bus_addr_hi = use_cap ? cap_addr_q : addr[ADDR_W-1:2];

  assign data_req   = req;
  assign data_wr    = req && bus_tag.wr;
  assign data_size  = req ? bus_tag.size : 2'b00;
  assign data_addr  = req ? ({bus_addr_hi, bus_tag.off} & ADDR_KEEP) : '0;
  assign data_wdata = req ? (use_cap ? cap_wdata_q : wdata) : 32'h0;

  always_comb begin
    lane = data_rdata >> {head_tag.off, 3'b000};
    case (head_tag.size)
      SZ_BYTE: ext = {{24{head_tag.sgn & lane[7]}}, lane[7:0]};
      SZ_HALF: ext = {{16{head_tag.sgn & lane[15]}}, lane[15:0]};
      default: ext = lane;
    endcase
  end

  assign load_data  = lv_c ? ext : 32'h0;
  assign load_valid = lv_c;
  assign be_err     = err_c;
  assign stall      = stall_c;
  assign CLR        = stall_c;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_data_sram_bridge                                              |
// | Directed vector bench for data_sram_bridge.                      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        MemRead;
  logic [3:0]  MemWrite;
  logic [1:0]  LoadSize;
  logic        LoadSigned;
  logic [31:0] addr, wdata, load_data;
  logic        load_valid, be_err, stall, CLR;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_sram_bridge #(.ADDR_W(32), .MAX_OUT(2), .MASK_HI(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .LoadSize     (LoadSize),
    .LoadSigned   (LoadSigned),
    .addr         (addr),
    .wdata        (wdata),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .be_err       (be_err),
    .stall        (stall),
    .CLR          (CLR)
  );

  typedef struct {
    logic        rd;
    logic [3:0]  we;
    logic [1:0]  ls;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdv;
    logic        e_req;
    logic        e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr;
    logic        e_err;
    logic        e_stall;
    logic        e_lv;
    logic [31:0] e_ld;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemRead    = 1'b0;
    MemWrite   = 4'b0000;
    LoadSize   = 2'b00;
    LoadSigned = 1'b0;
    addr       = 32'h0;
    wdata      = 32'h0;
  endtask

  task automatic drive_op(input logic rd, input logic [3:0] we, input logic [1:0] ls,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd);
    MemRead    = rd;
    MemWrite   = we;
    LoadSize   = ls;
    LoadSigned = sg;
    addr       = a;
    wdata      = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           rd we      ls     sg a             wd            rdv           req wr sz     e_addr        err st lv e_ld
    vecs[0]  = '{0, 4'b1111, 2'b00, 0, 32'hA000_0010, 32'h1234_5678, 32'h0,        1, 1, 2'b10, 32'h0000_0010, 0, 0, 0, 32'h0};
    vecs[1]  = '{0, 4'b0100, 2'b00, 0, 32'hE000_1230, 32'h00AB_0000, 32'h0,        1, 1, 2'b00, 32'h0000_1232, 0, 0, 0, 32'h0};
    vecs[2]  = '{0, 4'b1100, 2'b00, 0, 32'h2000_0044, 32'hCAFE_0000, 32'h0,        1, 1, 2'b01, 32'h0000_0046, 0, 0, 0, 32'h0};
    vecs[3]  = '{0, 4'b0010, 2'b00, 0, 32'h1000_0008, 32'h0000_5A00, 32'h0,        1, 1, 2'b00, 32'h1000_0009, 0, 0, 0, 32'h0};
    vecs[4]  = '{0, 4'b0011, 2'b00, 0, 32'h0000_0020, 32'h0000_1111, 32'h0,        1, 1, 2'b01, 32'h0000_0020, 0, 0, 0, 32'h0};
    vecs[5]  = '{0, 4'b0101, 2'b00, 0, 32'h0000_0030, 32'h0,         32'h0,        0, 0, 2'b00, 32'h0,         1, 0, 0, 32'h0};
    vecs[6]  = '{0, 4'b0110, 2'b00, 0, 32'h0000_0030, 32'h0,         32'h0,        0, 0, 2'b00, 32'h0,         1, 0, 0, 32'h0};
    vecs[7]  = '{0, 4'b1110, 2'b00, 0, 32'h0000_0030, 32'h0,         32'h0,        0, 0, 2'b00, 32'h0,         1, 0, 0, 32'h0};
    vecs[8]  = '{1, 4'b0000, 2'b01, 0, 32'h0000_0001, 32'h0,         32'h0,        0, 0, 2'b00, 32'h0,         1, 0, 0, 32'h0};
    vecs[9]  = '{1, 4'b0000, 2'b10, 0, 32'h0000_0002, 32'h0,         32'h0,        0, 0, 2'b00, 32'h0,         1, 0, 0, 32'h0};
    vecs[10] = '{1, 4'b0000, 2'b00, 1, 32'h8000_0003, 32'h0,         32'h80FF_FF00, 1, 0, 2'b00, 32'h0000_0003, 0, 1, 1, 32'hFFFF_FF80};
    vecs[11] = '{1, 4'b0000, 2'b00, 0, 32'h0000_0101, 32'h0,         32'h0000_9A00, 1, 0, 2'b00, 32'h0000_0101, 0, 1, 1, 32'h0000_009A};
    vecs[12] = '{1, 4'b0000, 2'b01, 1, 32'h0000_0002, 32'h0,         32'h8001_0000, 1, 0, 2'b01, 32'h0000_0002, 0, 1, 1, 32'hFFFF_8001};
    vecs[13] = '{1, 4'b0000, 2'b10, 1, 32'hFFFF_FFFC, 32'h0,         32'hDEAD_BEEF, 1, 0, 2'b10, 32'h1FFF_FFFC, 0, 1, 1, 32'hDEAD_BEEF};
    vecs[14] = '{1, 4'b0101, 2'b01, 0, 32'h0000_0006, 32'h0,         32'h7F00_0000, 1, 0, 2'b01, 32'h0000_0006, 0, 1, 1, 32'h0000_7F00};
    vecs[15] = '{1, 4'b0000, 2'b01, 0, 32'h0000_0006, 32'h0,         32'h8001_1234, 1, 0, 2'b01, 32'h0000_0006, 0, 1, 1, 32'h0000_8001};

    rst          = 1'b0;
    data_rdata   = 32'h0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    idle_inputs();

    // Reset state, including a live load request that must be suppressed.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", data_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_lv", load_valid, 0);
    chk("rst_err", be_err, 0);
    drive_op(1, 4'b0000, 2'b10, 0, 32'h0000_0040, 32'h0);
    data_addr_ok = 1'b1;
    #1;
    chk("rst_req_live", data_req, 0);
    chk("rst_addr_live", data_addr, 0);
    chk("rst_clr_live", CLR, 0);
    tick();
    idle_inputs();
    data_addr_ok = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      tick();
      drive_op(vecs[i].rd, vecs[i].we, vecs[i].ls, vecs[i].sg, vecs[i].a, vecs[i].wd);
      data_addr_ok = vecs[i].e_req;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), data_req, vecs[i].e_req);
      chk($sformatf("v%0d_wr", i), data_wr, vecs[i].e_wr);
      chk($sformatf("v%0d_size", i), data_size, vecs[i].e_size);
      chk($sformatf("v%0d_addr", i), data_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_err", i), be_err, vecs[i].e_err);
      chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
      chk($sformatf("v%0d_clr", i), CLR, vecs[i].e_stall);
      if (vecs[i].e_wr) chk($sformatf("v%0d_wdata", i), data_wdata, vecs[i].wd);
      tick();
      idle_inputs();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b1;
      data_rdata   = vecs[i].rdv;
      @(negedge clk);
      chk($sformatf("v%0d_lv", i), load_valid, vecs[i].e_lv);
      chk($sformatf("v%0d_ld", i), load_data, vecs[i].e_ld);
      chk($sformatf("v%0d_stall2", i), stall, 0);
      tick();
      data_data_ok = 1'b0;
    end

    // Load held in HDSK for three cycles; bus fields must come from the capture.
    tick();
    drive_op(1, 4'b0000, 2'b00, 1, 32'h8000_0003, 32'h0);
    data_addr_ok = 1'b0;
    @(negedge clk);
    chk("hd_issue_req", data_req, 1);
    chk("hd_issue_stall", stall, 1);
    tick();
    drive_op(0, 4'b1111, 2'b10, 0, 32'h5555_5554, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("hd1_req", data_req, 1);
    chk("hd1_wr", data_wr, 0);
    chk("hd1_size", data_size, 2'b00);
    chk("hd1_addr", data_addr, 32'h0000_0003);
    chk("hd1_stall", stall, 1);
    tick();
    @(negedge clk);
    chk("hd2_addr", data_addr, 32'h0000_0003);
    tick();
    data_addr_ok = 1'b1;
    @(negedge clk);
    chk("hd3_req", data_req, 1);
    chk("hd3_stall", stall, 1);
    tick();
    data_addr_ok = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("hd_wait_stall", stall, 1);
    chk("hd_wait_req", data_req, 0);
    chk("hd_wait_lv", load_valid, 0);
    tick();
    data_data_ok = 1'b1;
    data_rdata   = 32'h80FF_FF00;
    @(negedge clk);
    chk("hd_lv", load_valid, 1);
    chk("hd_ld", load_data, 32'hFFFF_FF80);
    chk("hd_stall", stall, 0);
    tick();
    data_data_ok = 1'b0;

    // Two posted stores fill the queue; the third waits in DRAIN.
    drive_op(0, 4'b1111, 2'b00, 0, 32'h0000_0100, 32'h1111_1111);
    data_addr_ok = 1'b1;
    @(negedge clk);
    chk("dr_s1_stall", stall, 0);
    tick();
    drive_op(0, 4'b0001, 2'b00, 0, 32'h0000_0104, 32'h0000_0022);
    @(negedge clk);
    chk("dr_s2_req", data_req, 1);
    chk("dr_s2_stall", stall, 0);
    tick();
    drive_op(0, 4'b1111, 2'b00, 0, 32'h0000_0108, 32'h3333_3333);
    data_addr_ok = 1'b0;
    @(negedge clk);
    chk("dr_s3_req", data_req, 0);
    chk("dr_s3_stall", stall, 1);
    tick();
    data_data_ok = 1'b1;
    @(negedge clk);
    chk("dr_pop_req", data_req, 0);
    chk("dr_pop_stall", stall, 1);
    chk("dr_pop_lv", load_valid, 0);
    tick();
    data_data_ok = 1'b0;
    data_addr_ok = 1'b1;
    @(negedge clk);
    chk("dr_reissue_req", data_req, 1);
    chk("dr_reissue_addr", data_addr, 32'h0000_0108);
    chk("dr_reissue_stall", stall, 0);
    tick();
    idle_inputs();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    @(negedge clk);
    chk("dr_drain1_lv", load_valid, 0);
    tick();
    @(negedge clk);
    chk("dr_drain2_lv", load_valid, 0);
    tick();
    data_data_ok = 1'b0;

    // Store then load with responses withheld.
    drive_op(0, 4'b1111, 2'b00, 0, 32'h0000_0200, 32'hAAAA_5555);
    data_addr_ok = 1'b1;
    @(negedge clk);
    chk("sl_st_stall", stall, 0);
    tick();
    drive_op(1, 4'b0000, 2'b01, 0, 32'h0000_0302, 32'h0);
    @(negedge clk);
    chk("sl_ld_addr", data_addr, 32'h0000_0302);
    chk("sl_ld_stall", stall, 1);
    tick();
    idle_inputs();
    data_addr_ok = 1'b0;
    @(negedge clk);
    chk("sl_wait_stall", stall, 1);
    tick();
    data_data_ok = 1'b1;
    data_rdata   = 32'h1234_5678;
    @(negedge clk);
    chk("sl_st_resp_lv", load_valid, 0);
    chk("sl_st_resp_ld", load_data, 0);
    chk("sl_st_resp_stall", stall, 1);
    tick();
    data_rdata = 32'hBEEF_0000;
    @(negedge clk);
    chk("sl_ld_lv", load_valid, 1);
    chk("sl_ld_data", load_data, 32'h0000_BEEF);
    chk("sl_ld_stall2", stall, 0);
    tick();
    data_data_ok = 1'b0;

    // Asynchronous reset while waiting for a load response.
    drive_op(1, 4'b0000, 2'b10, 0, 32'h0000_0040, 32'h0);
    data_addr_ok = 1'b1;
    @(negedge clk);
    chk("ar_issue_stall", stall, 1);
    tick();
    data_addr_ok = 1'b0;
    @(negedge clk);
    chk("ar_wait_stall", stall, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_stall", stall, 0);
    chk("ar_clr", CLR, 0);
    chk("ar_req", data_req, 0);
    chk("ar_lv", load_valid, 0);
    tick();
    rst = 1'b1;
    idle_inputs();
    data_data_ok = 1'b1;
    data_rdata   = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("ar_stale_lv", load_valid, 0);
    chk("ar_stale_ld", load_data, 0);
    chk("ar_stale_stall", stall, 0);
    tick();
    data_data_ok = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- MEM-stage data-side bridge from the pipeline's load/store controls to the SRAM-like data bus (req/addr_ok/data_ok).
- Successor to the blocking single-request data port, with these additions:
  - up to MAX_OUT in-flight transactions tracked by an in-order tag FIFO;
  - posted stores that release the pipeline once the address is accepted;
  - exact load sizing with sign/zero extension;
  - detection of illegal byte-enables and misaligned accesses.

Parameters:
- ADDR_W, 32: bus address width.
- MAX_OUT, 2: maximum outstanding transactions (tag FIFO depth), ≥1. MAX_OUT=1 gives fully blocking behaviour.
- MASK_HI, 3: number of top address bits forced to 0 on data_addr (kseg-to-physical strip).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- data_req  out  1  bus request
- data_wr  out  1  1=write
- data_size  out  2  00 byte, 01 half, 10 word
- data_addr  out  ADDR_W  byte address, top MASK_HI bits zero
- data_wdata  out  32  write data, passed through unshifted
- data_rdata  in  32  read data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response for the oldest in-flight transaction
- MemRead  in  1  load request
- MemWrite  in  4  store byte enables
- LoadSize  in  2  00 byte, 01 half, 10 word
- LoadSigned  in  1  sign-extend a sub-word load
- addr  in  ADDR_W  effective address
- wdata  in  32  store data, already lane-aligned
- load_data  out  32  extracted and extended load result
- load_valid  out  1  load_data valid this cycle
- be_err  out  1  one-cycle pulse for an illegal or misaligned op
- stall  out  1  hold the pipeline
- CLR  out  1  flush the next stage; always equal to stall

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, FIFO empty, capture registers cleared.
  - All outputs 0.
  - A data_ok arriving with the FIFO empty is ignored.
- Legality (combinational):
  - Legal MemWrite codes: 0001/0010/0100/1000 (byte), 0011/1100 (half), 1111 (word).
  - A load is misaligned if it is half with addr[0]=1, or word with addr[1:0]≠0.
  - Any other nonzero MemWrite, or a misaligned load, gives be_err=1 for one cycle, no bus request, stall=0.
  - MemRead has priority over MemWrite.
- Request encoding:
  - Store: data_size and data_addr[1:0] are derived from the byte-enable code.
  - Load: data_size=LoadSize, data_addr[1:0]=addr[1:0].
  - data_addr[ADDR_W-1:ADDR_W-MASK_HI]=0.
- FSM states: IDLE, HDSK, WAITLD, DRAIN.
- IDLE, legal op present:
  - If the FIFO is not full, drive data_req=1 from the live inputs and capture addr/wdata/MemWrite/LoadSize/LoadSigned.
  - If the FIFO is full, go to DRAIN with data_req=0 and stall=1.
  - On addr_ok, push tag {wr, addr[1:0], size, signed}:
    - store: stall=0 in this same cycle, stay IDLE;
    - load: go to WAITLD, stall=1.
  - Without addr_ok: go to HDSK, stall=1.
- HDSK:
  - data_req=1, with every bus field driven from the capture registers only.
  - Held until addr_ok, then handled as the IDLE accept case.
- DRAIN:
  - stall=1, data_req=0.
  - Return to IDLE when a pop frees a slot. The request issues in the next cycle.
- WAITLD:
  - stall=1. Each data_ok pops the oldest tag.
  - When the popped tag is the pending load: load_valid=1, stall=0 in that cycle, next state IDLE.
  - Earlier store responses are popped silently.
- FIFO:
  - Push only when count<MAX_OUT. A pop in the same cycle does not enable a push.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo MAX_OUT.
- Load extraction:
  - lane = rdata >> (8 × popped offset).
  - Byte: [7:0], half: [15:0], word: all 32 bits.
  - Sign or zero extension per the popped signed bit.
  - load_data=0 whenever load_valid=0.
- No data_ok response produces an output for a store.
- Latency:
  - Store: zero extra cycles if addr_ok arrives in the issue cycle.
  - Load: completes on the cycle of its own data_ok, combinational from data_rdata.

Decomposition:
- Shared package (mem_pkg):
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encodings;
  - tag struct {wr, off[1:0], size[1:0], sgn};
  - legal byte-enable constants.
- One sub-module: tag_fifo.
  - Synchronous FIFO with asynchronous active-low reset.
  - Parameters DEPTH and WIDTH.
  - Signals push, pop, full, empty, head.

Test Plan:
- MemWrite=1111, addr=0xA000_0010, wdata=0x1234_5678, addr_ok in the same cycle:
  - data_req=1, data_wr=1, data_size=10, data_addr=0x0000_0010, stall=0 that cycle.
  - data_ok two cycles later: no load_valid.
- MemRead, LoadSize=00, LoadSigned=1, addr=0x8000_0003, addr_ok delayed 3 cycles, data_rdata=0x80FF_FF00:
  - HDSK holds data_addr=0x0000_0003 and data_size=00.
  - On data_ok: load_data=0xFFFF_FF80, load_valid=1, stall=0.
- MAX_OUT=2: two back-to-back stores accepted without data_ok, then a third store:
  - third store: data_req=0, stall=1 (DRAIN);
  - the first data_ok frees a slot, and the third store issues the following cycle.
- Store then load with data_ok withheld:
  - the first data_ok (store) gives no load_valid;
  - the second data_ok gives load_valid with the half-zero-extended value 0x0000_BEEF from rdata=0xBEEF_0000, off=2.
- MemWrite=0101, or a half load at addr=0x1:
  - be_err=1 for one cycle, data_req=0, stall=0.
- rst=0 asserted mid-WAITLD:
  - all outputs drop to 0 immediately;
  - a later stale data_ok produces no load_valid.
